// File: rtl/stopwatch_counter.sv
// BCD mm:ss stopwatch advanced by the sampled 1 Hz level from the clock divider,
// with run/pause control and a manual adjust mode stepped by the 2 Hz adjust level.
module stopwatch_counter #(
    parameter int MAX_MIN = 59,
    parameter int MAX_SEC = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seconds_clk,
    input  logic       adj_clk,
    input  logic       pause_toggle,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       rollover
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    localparam logic [3:0] MAX_MIN_T = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_MIN_O = 4'(MAX_MIN % 10);
    localparam logic [3:0] MAX_SEC_T = 4'(MAX_SEC / 10);
    localparam logic [3:0] MAX_SEC_O = 4'(MAX_SEC % 10);

    state_t state_r;
    logic   sec_d1_r;
    logic   adj_d1_r;
    logic   sec_tick_s;
    logic   adj_tick_s;
    logic   sec_at_max_s;
    logic   min_at_max_s;

    // Next BCD value of a two-digit field; a field already at its maximum wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones,
                                           input logic [3:0] max_t, input logic [3:0] max_o);
        logic [7:0] res;
        if ((tens == max_t) && (ones == max_o)) begin
            res = 8'h00;
        end else if (ones == 4'd9) begin
            res = {tens + 4'd1, 4'd0};
        end else begin
            res = {tens, ones + 4'd1};
        end
        return res;
    endfunction

    assign sec_tick_s   = seconds_clk & ~sec_d1_r;
    assign adj_tick_s   = adj_clk & ~adj_d1_r;
    assign sec_at_max_s = (sec_tens == MAX_SEC_T) && (sec_ones == MAX_SEC_O);
    assign min_at_max_s = (min_tens == MAX_MIN_T) && (min_ones == MAX_MIN_O);

    // Mode FSM, edge-detect history and the BCD count, all with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_RUN;
            sec_d1_r <= 1'b1;   // a level already high at release must not count
            adj_d1_r <= 1'b1;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            running  <= 1'b1;
            rollover <= 1'b0;
        end else begin
            sec_d1_r <= seconds_clk;
            adj_d1_r <= adj_clk;
            rollover <= 1'b0;
            case (state_r)
                ST_RUN: begin
                    if (adj) begin
                        state_r <= ST_ADJUST;
                        running <= 1'b0;
                    end else begin
                        if (sec_tick_s) begin
                            {sec_tens, sec_ones} <= bcd_inc(sec_tens, sec_ones, MAX_SEC_T, MAX_SEC_O);
                            if (sec_at_max_s) begin
                                {min_tens, min_ones} <= bcd_inc(min_tens, min_ones, MAX_MIN_T, MAX_MIN_O);
                                if (min_at_max_s) begin
                                    rollover <= 1'b1;
                                end
                            end
                        end
                        if (pause_toggle) begin
                            state_r <= ST_PAUSED;
                            running <= 1'b0;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (adj) begin
                        state_r <= ST_ADJUST;
                        running <= 1'b0;
                    end else if (pause_toggle) begin
                        state_r <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_ADJUST: begin
                    // Leaving adjust takes priority over a coincident adjust step.
                    if (!adj) begin
                        state_r <= ST_PAUSED;
                        running <= 1'b0;
                    end else if (adj_tick_s) begin
                        if (sel) begin
                            {sec_tens, sec_ones} <= bcd_inc(sec_tens, sec_ones, MAX_SEC_T, MAX_SEC_O);
                        end else begin
                            {min_tens, min_ones} <= bcd_inc(min_tens, min_ones, MAX_MIN_T, MAX_MIN_O);
                        end
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                    running <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter: directed scenarios plus random stimulus,
// expectations from an integer mm/ss reference model, checked by an independent monitor.
module tb_stopwatch_counter;

    localparam int MAX_MIN = 59;
    localparam int MAX_SEC = 59;
    localparam int M_RUN = 0, M_PAUSED = 1, M_ADJUST = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       seconds_clk = 1'b0;
    logic       adj_clk = 1'b0;
    logic       pause_toggle = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, rollover;

    stopwatch_counter #(.MAX_MIN(MAX_MIN), .MAX_SEC(MAX_SEC)) dut (
        .clk(clk), .rst(rst), .seconds_clk(seconds_clk), .adj_clk(adj_clk),
        .pause_toggle(pause_toggle), .adj(adj), .sel(sel),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .rollover(rollover)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [17:0] exp_q[$];

    // reference model state
    int m_mm = 0, m_ss = 0, m_mode = M_RUN, m_roll = 0;
    int m_prev_sec = 1, m_prev_adj = 1;

    // current stimulus levels
    logic cur_sc = 1'b0, cur_ac = 1'b0, cur_adj = 1'b0, cur_sel = 1'b0;

    function automatic logic [17:0] pack_exp(input int mm, input int ss, input int mode, input int roll);
        logic [17:0] v;
        v = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), (mode == M_RUN), (roll != 0)};
        return v;
    endfunction

    task automatic model_update(input logic r, input logic sc, input logic ac,
                                input logic pt, input logic a, input logic s);
        int stick, atick;
        if (r) begin
            m_mm = 0; m_ss = 0; m_mode = M_RUN; m_roll = 0;
            m_prev_sec = 1; m_prev_adj = 1;
        end else begin
            stick = (sc && m_prev_sec == 0) ? 1 : 0;
            atick = (ac && m_prev_adj == 0) ? 1 : 0;
            m_prev_sec = sc ? 1 : 0;
            m_prev_adj = ac ? 1 : 0;
            m_roll = 0;
            if (m_mode == M_RUN) begin
                if (a) m_mode = M_ADJUST;
                else begin
                    if (stick != 0) begin
                        if (m_ss == MAX_SEC) begin
                            m_ss = 0;
                            if (m_mm == MAX_MIN) begin m_mm = 0; m_roll = 1; end
                            else m_mm = m_mm + 1;
                        end else m_ss = m_ss + 1;
                    end
                    if (pt) m_mode = M_PAUSED;
                end
            end else if (m_mode == M_PAUSED) begin
                if (a) m_mode = M_ADJUST;
                else if (pt) m_mode = M_RUN;
            end else begin
                if (!a) m_mode = M_PAUSED;
                else if (atick != 0) begin
                    if (s) m_ss = (m_ss == MAX_SEC) ? 0 : m_ss + 1;
                    else   m_mm = (m_mm == MAX_MIN) ? 0 : m_mm + 1;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic pt);
        @(negedge clk);
        rst = r; seconds_clk = cur_sc; adj_clk = cur_ac;
        pause_toggle = pt; adj = cur_adj; sel = cur_sel;
        model_update(r, cur_sc, cur_ac, pt, cur_adj, cur_sel);
        exp_q.push_back(pack_exp(m_mm, m_ss, m_mode, m_roll));
    endtask

    task automatic sec_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            cur_sc = 1'b1; step(1'b0, 1'b0); step(1'b0, 1'b0);
            cur_sc = 1'b0; step(1'b0, 1'b0); step(1'b0, 1'b0);
        end
    endtask

    task automatic adj_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            cur_ac = 1'b1; step(1'b0, 1'b0);
            cur_ac = 1'b0; step(1'b0, 1'b0);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare each against the oldest expectation.
    initial begin
        logic [17:0] e, got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {min_tens, min_ones, sec_tens, sec_ones, running, rollover};
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got %h%h:%h%h run=%b roll=%b, required %h%h:%h%h run=%b roll=%b",
                             $time, got[17:14], got[13:10], got[9:6], got[5:2], got[1], got[0],
                             e[17:14], e[13:10], e[9:6], e[5:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        // reset then 3 seconds
        step(1'b1, 1'b0); step(1'b1, 1'b0);
        sec_pulses(3);
        // pause, ticks ignored, resume, one tick counts
        step(1'b0, 1'b1);
        sec_pulses(5);
        step(1'b0, 1'b1);
        sec_pulses(1);
        // preset 59:58 via adjust, with seconds ticks ignored meanwhile
        step(1'b1, 1'b0);
        cur_adj = 1'b1; cur_sel = 1'b0; step(1'b0, 1'b0);
        adj_pulses(59);
        sec_pulses(2);
        cur_sel = 1'b1; adj_pulses(58);
        cur_adj = 1'b0; step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        sec_pulses(3);
        // seconds wrap in adjust leaves minutes alone, then minutes +4
        cur_adj = 1'b1; cur_sel = 1'b1; step(1'b0, 1'b0);
        adj_pulses(58);
        adj_pulses(1);
        cur_sel = 1'b0; adj_pulses(4);
        cur_adj = 1'b0; step(1'b0, 1'b0); step(1'b0, 1'b1);
        // seconds level held high across reset release
        cur_sc = 1'b1; step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        cur_sc = 1'b0; step(1'b0, 1'b0);
        sec_pulses(2);
        // reset mid-count at 12:34
        step(1'b1, 1'b0);
        cur_adj = 1'b1; cur_sel = 1'b0; step(1'b0, 1'b0); adj_pulses(12);
        cur_sel = 1'b1; adj_pulses(34);
        cur_adj = 1'b0; step(1'b0, 1'b0); step(1'b0, 1'b1);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        // randomized traffic including simultaneous events
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2) == 0)  cur_sc  = ~cur_sc;
            if ($urandom_range(2) == 0)  cur_ac  = ~cur_ac;
            if ($urandom_range(40) == 0) cur_adj = ~cur_adj;
            if ($urandom_range(9) == 0)  cur_sel = ~cur_sel;
            step(($urandom_range(400) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(12) == 0) ? 1'b1 : 1'b0);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
